// File: rtl/ec_point_engine_pkg.sv
// Shared definitions for the elliptic-curve point engine and its field ALU:
// default curve parameters, ALU op codes and FSM state encodings.
package ec_point_engine_pkg;

    localparam int DEF_DATAWIDTH = 5;
    localparam int DEF_P_MOD     = 23;
    localparam int DEF_A_COEF    = 1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_DBL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DBL,
        ST_ADD,
        ST_DONE
    } eng_state_e;

    typedef enum logic [1:0] {
        ALU_IDLE,
        ALU_INV,
        ALU_FIN
    } alu_state_e;

endpackage

// File: rtl/ec_point_engine_alu.sv
// Affine point add/double over GF(P_MOD). The slope denominator is inverted by
// Fermat exponentiation (den^(P_MOD-2)), one exponent bit per cycle.
module ec_point_alu
    import ec_point_engine_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int P_MOD     = DEF_P_MOD,
    parameter int A_COEF    = DEF_A_COEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 op_i,
    input  logic [DATAWIDTH-1:0] x1_i,
    input  logic [DATAWIDTH-1:0] y1_i,
    input  logic [DATAWIDTH-1:0] x2_i,
    input  logic [DATAWIDTH-1:0] y2_i,
    output logic                 done_o,
    output logic [DATAWIDTH-1:0] x3_o,
    output logic [DATAWIDTH-1:0] y3_o
);
    typedef logic [DATAWIDTH-1:0]   word_t;
    typedef logic [DATAWIDTH:0]     wide_t;
    typedef logic [2*DATAWIDTH-1:0] dbl_t;
    localparam int BW = $clog2(DATAWIDTH + 1);
    localparam word_t EXP = word_t'(P_MOD - 2);
    localparam logic [BW-1:0] TOP_BIT = BW'(DATAWIDTH - 1);

    function automatic word_t modAdd(input word_t a, input word_t b);
        wide_t s;
        s = wide_t'(a) + wide_t'(b);
        if (s >= wide_t'(P_MOD)) s = s - wide_t'(P_MOD);
        return word_t'(s);
    endfunction

    function automatic word_t modSub(input word_t a, input word_t b);
        return modAdd(a, (b == '0) ? '0 : word_t'(P_MOD) - b);
    endfunction

    function automatic word_t modMul(input word_t a, input word_t b);
        dbl_t prod;
        prod = dbl_t'(a) * dbl_t'(b);
        return word_t'(prod % dbl_t'(P_MOD));
    endfunction

    alu_state_e    stateQ, stateD;
    word_t         x1Q, y1Q, x2Q, numQ, denQ, accQ, x3Q, y3Q;
    word_t         x1D, y1D, x2D, numD, denD, accD, x3D, y3D;
    logic [BW-1:0] bitQ, bitD;
    logic          doneQ, doneD;
    word_t         sqX, numIn, denIn, accSq, accNext, lambda, x3n, y3n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ALU_IDLE;
            x1Q <= '0; y1Q <= '0; x2Q <= '0; numQ <= '0; denQ <= '0;
            accQ <= '0; x3Q <= '0; y3Q <= '0; bitQ <= '0; doneQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            x1Q <= x1D; y1Q <= y1D; x2Q <= x2D; numQ <= numD; denQ <= denD;
            accQ <= accD; x3Q <= x3D; y3Q <= y3D; bitQ <= bitD; doneQ <= doneD;
        end
    end

    // A new start always wins, so a stale operation left by an aborted request is simply dropped.
    always_comb begin
        stateD = stateQ;
        x1D = x1Q; y1D = y1Q; x2D = x2Q; numD = numQ; denD = denQ;
        accD = accQ; x3D = x3Q; y3D = y3Q; bitD = bitQ; doneD = 1'b0;

        sqX = modMul(x1_i, x1_i);
        if (op_i == OP_DBL) begin
            numIn = modAdd(modAdd(modAdd(sqX, sqX), sqX), word_t'(A_COEF));
            denIn = modAdd(y1_i, y1_i);
        end else begin
            numIn = modSub(y2_i, y1_i);
            denIn = modSub(x2_i, x1_i);
        end
        accSq   = modMul(accQ, accQ);
        accNext = EXP[bitQ] ? modMul(accSq, denQ) : accSq;
        lambda  = modMul(numQ, accQ);
        x3n     = modSub(modSub(modMul(lambda, lambda), x1Q), x2Q);
        y3n     = modSub(modMul(lambda, modSub(x1Q, x3n)), y1Q);

        if (start_i) begin
            x1D = x1_i;
            y1D = y1_i;
            x2D = (op_i == OP_DBL) ? x1_i : x2_i;
            numD = numIn;
            denD = denIn;
            accD = word_t'(1);
            bitD = TOP_BIT;
            stateD = ALU_INV;
        end else begin
            case (stateQ)
                ALU_INV: begin
                    accD = accNext;
                    if (bitQ == '0) stateD = ALU_FIN;
                    else            bitD = bitQ - BW'(1);
                end
                ALU_FIN: begin
                    x3D = x3n;
                    y3D = y3n;
                    doneD = 1'b1;
                    stateD = ALU_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign done_o = doneQ;
    assign x3_o   = x3Q;
    assign y3_o   = y3Q;

endmodule

// File: rtl/ec_point_engine.sv
// Point-arithmetic responder: k*P by left-to-right double-and-add, or P+P2,
// resolving every infinity/special case locally and using the ALU only for general ops.
module ec_point_engine
    import ec_point_engine_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int P_MOD     = DEF_P_MOD,
    parameter int A_COEF    = DEF_A_COEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [DATAWIDTH-1:0] k,
    input  logic [DATAWIDTH-1:0] Px,
    input  logic [DATAWIDTH-1:0] Py,
    input  logic [DATAWIDTH-1:0] P2x,
    input  logic [DATAWIDTH-1:0] P2y,
    output logic [DATAWIDTH-1:0] Qx,
    output logic [DATAWIDTH-1:0] Qy,
    output logic                 qInf,
    output logic                 outReady
);
    typedef logic [DATAWIDTH-1:0] word_t;
    localparam int CW = $clog2(DATAWIDTH + 1);

    eng_state_e    stateQ, stateD;
    logic          modeQ, modeD, rInfQ, rInfD, sInfQ, sInfD, busyQ, busyD;
    logic          aluStartQ, aluStartD, aluOpQ, aluOpD, qInfQ, qInfD, outReadyQ, outReadyD;
    word_t         kQ, kD, rxQ, rxD, ryQ, ryD, sxQ, sxD, syQ, syD, qxQ, qxD, qyQ, qyD;
    logic [CW-1:0] bitcntQ, bitcntD;
    logic          doStep, aluDone;
    word_t         negSy, aluX3, aluY3;

    assign negSy = (syQ == '0) ? '0 : word_t'(P_MOD) - syQ;

    ec_point_alu #(.DATAWIDTH(DATAWIDTH), .P_MOD(P_MOD), .A_COEF(A_COEF)) u_alu (
        .clk(clk), .rst_n(rst_n), .start_i(aluStartQ), .op_i(aluOpQ),
        .x1_i(rxQ), .y1_i(ryQ), .x2_i(sxQ), .y2_i(syQ),
        .done_o(aluDone), .x3_o(aluX3), .y3_o(aluY3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_IDLE;
            modeQ <= 1'b0; rInfQ <= 1'b0; sInfQ <= 1'b0; busyQ <= 1'b0;
            aluStartQ <= 1'b0; aluOpQ <= OP_ADD; qInfQ <= 1'b0; outReadyQ <= 1'b0;
            kQ <= '0; rxQ <= '0; ryQ <= '0; sxQ <= '0; syQ <= '0;
            qxQ <= '0; qyQ <= '0; bitcntQ <= '0;
        end else begin
            stateQ <= stateD;
            modeQ <= modeD; rInfQ <= rInfD; sInfQ <= sInfD; busyQ <= busyD;
            aluStartQ <= aluStartD; aluOpQ <= aluOpD; qInfQ <= qInfD; outReadyQ <= outReadyD;
            kQ <= kD; rxQ <= rxD; ryQ <= ryD; sxQ <= sxD; syQ <= syD;
            qxQ <= qxD; qyQ <= qyD; bitcntQ <= bitcntD;
        end
    end

    // R is the running accumulator and S the fixed addend (P for multiply, P2 for add).
    // kQ's MSB is always the next scalar bit to process; doStep consumes it.
    always_comb begin
        stateD = stateQ; modeD = modeQ; rInfD = rInfQ; sInfD = sInfQ; busyD = busyQ;
        aluStartD = 1'b0; aluOpD = aluOpQ; qInfD = qInfQ; outReadyD = outReadyQ;
        kD = kQ; rxD = rxQ; ryD = ryQ; sxD = sxQ; syD = syQ;
        qxD = qxQ; qyD = qyQ; bitcntD = bitcntQ;
        doStep = 1'b0;

        if (stateQ != ST_IDLE && !enable) begin
            stateD = ST_IDLE;
            busyD = 1'b0;
            outReadyD = 1'b0;
        end else begin
            case (stateQ)
                ST_IDLE: if (enable && !outReadyQ) begin
                    modeD = mode;
                    kD = k;
                    bitcntD = CW'(DATAWIDTH);
                    rxD = Px;
                    ryD = Py;
                    rInfD = (Px == '0) && (Py == '0);
                    sxD = mode ? Px : P2x;
                    syD = mode ? Py : P2y;
                    sInfD = mode ? ((Px == '0) && (Py == '0)) : ((P2x == '0) && (P2y == '0));
                    stateD = mode ? ST_SCAN : ST_ADD;
                end
                ST_SCAN: begin
                    if (kQ == '0 || sInfQ) begin
                        rInfD = 1'b1;
                        stateD = ST_DONE;
                    end else if (kQ[DATAWIDTH-1]) begin
                        doStep = 1'b1;
                    end else begin
                        kD = kQ << 1;
                        bitcntD = bitcntQ - CW'(1);
                    end
                end
                ST_DBL: begin
                    if (!busyQ && !rInfQ && ryQ != '0) begin
                        aluStartD = 1'b1;
                        aluOpD = OP_DBL;
                        busyD = 1'b1;
                    end else if (!busyQ || aluDone) begin
                        if (busyQ) begin
                            rxD = aluX3;
                            ryD = aluY3;
                            busyD = 1'b0;
                        end else begin
                            rInfD = 1'b1;
                        end
                        if (kQ[DATAWIDTH-1]) stateD = ST_ADD;
                        else                 doStep = 1'b1;
                    end
                end
                ST_ADD: begin
                    if (busyQ) begin
                        if (aluDone) begin
                            rxD = aluX3;
                            ryD = aluY3;
                            busyD = 1'b0;
                            if (modeQ) doStep = 1'b1;
                            else       stateD = ST_DONE;
                        end
                    end else if (!sInfQ && !rInfQ && rxQ == sxQ && ryQ == syQ && ryQ != '0) begin
                        aluStartD = 1'b1;
                        aluOpD = OP_DBL;
                        busyD = 1'b1;
                    end else if (!sInfQ && !rInfQ && rxQ != sxQ) begin
                        aluStartD = 1'b1;
                        aluOpD = OP_ADD;
                        busyD = 1'b1;
                    end else begin
                        if (rInfQ) begin
                            rxD = sxQ;
                            ryD = syQ;
                            rInfD = sInfQ;
                        end else if (!sInfQ && (ryQ == syQ || ryQ == negSy)) begin
                            rInfD = 1'b1;
                        end
                        if (modeQ) doStep = 1'b1;
                        else       stateD = ST_DONE;
                    end
                end
                ST_DONE: if (!outReadyQ) begin
                    qxD = rInfQ ? '0 : rxQ;
                    qyD = rInfQ ? '0 : ryQ;
                    qInfD = rInfQ;
                    outReadyD = 1'b1;
                end
                default: stateD = ST_IDLE;
            endcase
        end

        if (doStep) begin
            kD = kQ << 1;
            bitcntD = bitcntQ - CW'(1);
            stateD = (bitcntQ == CW'(1)) ? ST_DONE : ST_DBL;
        end
    end

    assign Qx       = qxQ;
    assign Qy       = qyQ;
    assign qInf     = qInfQ;
    assign outReady = outReadyQ;

endmodule

// File: tb/tb_ec_point_engine.sv
// Directed bench for ec_point_engine on y^2 = x^3 + x + 1 over GF(23), G=(3,10), order 28.
module tb_ec_point_engine;
    logic       clk = 1'b0;
    logic       rst_n, enable, mode;
    logic [4:0] k, Px, Py, P2x, P2y, Qx, Qy;
    logic       qInf, outReady;
    int         checks = 0;
    int         fails = 0;
    int         aluStarts = 0;

    ec_point_engine #(.DATAWIDTH(5), .P_MOD(23), .A_COEF(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .k(k),
        .Px(Px), .Py(Py), .P2x(P2x), .P2y(P2y),
        .Qx(Qx), .Qy(Qy), .qInf(qInf), .outReady(outReady)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.aluStartQ) aluStarts <= aluStarts + 1;

    task automatic applyStimulus(input logic m, input logic [4:0] kk, input logic [4:0] px,
                                 input logic [4:0] py, input logic [4:0] p2x, input logic [4:0] p2y,
                                 output bit timedOut, output int starts);
        int s0;
        @(negedge clk);
        s0 = aluStarts;
        enable = 1'b1; mode = m; k = kk; Px = px; Py = py; P2x = p2x; P2y = p2y;
        @(negedge clk);
        k = ~kk; Px = ~px; Py = 5'd1; P2x = ~p2x; P2y = 5'd2; mode = ~m;
        timedOut = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (outReady) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        starts = aluStarts - s0;
    endtask

    task automatic releaseRequest();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; k = '0;
        Px = '0; Py = '0; P2x = '0; P2y = '0;
        repeat (3) @(negedge clk);
        checks++; if (Qx !== 5'd0) begin fails++; $display("[TB] FAIL reset_Qx: got %0d expected 0", Qx); end
        checks++; if (Qy !== 5'd0) begin fails++; $display("[TB] FAIL reset_Qy: got %0d expected 0", Qy); end
        checks++; if (qInf !== 1'b0) begin fails++; $display("[TB] FAIL reset_qInf: got %b expected 0", qInf); end
        checks++; if (outReady !== 1'b0) begin fails++; $display("[TB] FAIL reset_outReady: got %b expected 0", outReady); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        bit to; int st;
        applyStimulus(1'b0, 5'd0, 5'd3, 5'd10, 5'd9, 5'd7, to, st);
        checks++; if (to) begin fails++; $display("[TB] FAIL add_timeout: outReady got 0 expected 1"); end
        checks++; if (Qx !== 5'd17 || Qy !== 5'd20) begin fails++; $display("[TB] FAIL add_Q: got (%0d,%0d) expected (17,20)", Qx, Qy); end
        checks++; if (qInf !== 1'b0) begin fails++; $display("[TB] FAIL add_qInf: got %b expected 0", qInf); end
        checks++; if (st != 1) begin fails++; $display("[TB] FAIL add_aluStarts: got %0d expected 1", st); end
        repeat (4) @(negedge clk);
        checks++; if (outReady !== 1'b1 || Qx !== 5'd17) begin fails++; $display("[TB] FAIL add_hold: got ready=%b Qx=%0d expected ready=1 Qx=17", outReady, Qx); end
        releaseRequest();
        checks++; if (outReady !== 1'b0) begin fails++; $display("[TB] FAIL add_release: got %b expected 0", outReady); end
        checks++; if (Qx !== 5'd17 || Qy !== 5'd20) begin fails++; $display("[TB] FAIL add_keepQ: got (%0d,%0d) expected (17,20)", Qx, Qy); end
    endtask

    task automatic test_mult();
        bit to; int st;
        applyStimulus(1'b1, 5'd2, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || Qx !== 5'd7 || Qy !== 5'd12 || qInf !== 1'b0) begin fails++; $display("[TB] FAIL mult_k2: got to=%b (%0d,%0d) inf=%b expected (7,12) inf=0", to, Qx, Qy, qInf); end
        releaseRequest();
        applyStimulus(1'b1, 5'd1, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || Qx !== 5'd3 || Qy !== 5'd10 || qInf !== 1'b0) begin fails++; $display("[TB] FAIL mult_k1: got to=%b (%0d,%0d) inf=%b expected (3,10) inf=0", to, Qx, Qy, qInf); end
        checks++; if (st != 0) begin fails++; $display("[TB] FAIL mult_k1_aluStarts: got %0d expected 0", st); end
        releaseRequest();
        applyStimulus(1'b1, 5'd27, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || Qx !== 5'd3 || Qy !== 5'd13 || qInf !== 1'b0) begin fails++; $display("[TB] FAIL mult_k27: got to=%b (%0d,%0d) inf=%b expected (3,13) inf=0", to, Qx, Qy, qInf); end
        checks++; if (st != 7) begin fails++; $display("[TB] FAIL mult_k27_aluStarts: got %0d expected 7", st); end
        releaseRequest();
    endtask

    task automatic test_infinity();
        bit to; int st;
        applyStimulus(1'b1, 5'd28, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || qInf !== 1'b1 || Qx !== 5'd0 || Qy !== 5'd0) begin fails++; $display("[TB] FAIL mult_k28: got to=%b (%0d,%0d) inf=%b expected (0,0) inf=1", to, Qx, Qy, qInf); end
        releaseRequest();
        applyStimulus(1'b1, 5'd0, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || qInf !== 1'b1 || Qx !== 5'd0 || Qy !== 5'd0) begin fails++; $display("[TB] FAIL mult_k0: got to=%b (%0d,%0d) inf=%b expected (0,0) inf=1", to, Qx, Qy, qInf); end
        checks++; if (st != 0) begin fails++; $display("[TB] FAIL mult_k0_aluStarts: got %0d expected 0", st); end
        releaseRequest();
    endtask

    task automatic test_special_add();
        bit to; int st;
        applyStimulus(1'b0, 5'd0, 5'd3, 5'd10, 5'd3, 5'd13, to, st);
        checks++; if (to || qInf !== 1'b1 || Qx !== 5'd0 || Qy !== 5'd0 || st != 0) begin fails++; $display("[TB] FAIL add_neg: got to=%b (%0d,%0d) inf=%b starts=%0d expected (0,0) inf=1 starts=0", to, Qx, Qy, qInf, st); end
        releaseRequest();
        applyStimulus(1'b0, 5'd0, 5'd3, 5'd10, 5'd3, 5'd10, to, st);
        checks++; if (to || qInf !== 1'b0 || Qx !== 5'd7 || Qy !== 5'd12) begin fails++; $display("[TB] FAIL add_same: got to=%b (%0d,%0d) inf=%b expected (7,12) inf=0", to, Qx, Qy, qInf); end
        releaseRequest();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd7, to, st);
        checks++; if (to || qInf !== 1'b0 || Qx !== 5'd9 || Qy !== 5'd7 || st != 0) begin fails++; $display("[TB] FAIL add_inf_lhs: got to=%b (%0d,%0d) inf=%b starts=%0d expected (9,7) inf=0 starts=0", to, Qx, Qy, qInf, st); end
        releaseRequest();
    endtask

    task automatic test_abort();
        bit to; bit sawReady; int st;
        sawReady = 1'b0;
        @(negedge clk);
        enable = 1'b1; mode = 1'b1; k = 5'd27; Px = 5'd3; Py = 5'd10;
        repeat (10) begin @(negedge clk); if (outReady) sawReady = 1'b1; end
        enable = 1'b0;
        repeat (80) begin @(negedge clk); if (outReady) sawReady = 1'b1; end
        checks++; if (sawReady) begin fails++; $display("[TB] FAIL abort_ready: got outReady=1 expected 0"); end
        applyStimulus(1'b1, 5'd2, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || Qx !== 5'd7 || Qy !== 5'd12 || qInf !== 1'b0) begin fails++; $display("[TB] FAIL abort_next: got to=%b (%0d,%0d) inf=%b expected (7,12) inf=0", to, Qx, Qy, qInf); end
        releaseRequest();
    endtask

    task automatic test_reset_mid();
        bit to; int st;
        @(negedge clk);
        enable = 1'b1; mode = 1'b1; k = 5'd27; Px = 5'd3; Py = 5'd10;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Qx !== 5'd0 || Qy !== 5'd0 || qInf !== 1'b0 || outReady !== 1'b0) begin fails++; $display("[TB] FAIL reset_mid: got (%0d,%0d) inf=%b ready=%b expected all 0", Qx, Qy, qInf, outReady); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd2, 5'd3, 5'd10, 5'd0, 5'd0, to, st);
        checks++; if (to || Qx !== 5'd7 || Qy !== 5'd12 || qInf !== 1'b0) begin fails++; $display("[TB] FAIL reset_mid_next: got to=%b (%0d,%0d) inf=%b expected (7,12) inf=0", to, Qx, Qy, qInf); end
        releaseRequest();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_infinity();
        test_special_add();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
